// File: rtl/hs32_pkg.sv
// Shared types for the hs32 address-generation stage: the stage-2/stage-3
// memory-op packets, the access-size encoding and store-lane replication.
package hs32_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_WORD3 = 2'd3
  } hs32_size_e;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic [3:0]  rd;
    logic        pre;
    logic        wb_base;
    logic [31:0] base;
    logic [15:0] offset;
    logic [31:0] sdata;
  } hs32_s2pkt;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  rd;
    logic        wb_base;
    logic [31:0] base_nxt;
  } hs32_s3pkt;

  // Copy the active store bytes onto every lane; size 3 behaves as a word.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] sdata);
    logic [31:0] lanes;
    case (hs32_size_e'(size))
      SZ_BYTE: lanes = {4{sdata[7:0]}};
      SZ_HALF: lanes = {2{sdata[15:0]}};
      default: lanes = sdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/hs32_skid2.sv
// Two-entry in-order skid buffer whose upstream ready is a flop, so downstream
// back-pressure never reaches the producer combinationally.
module hs32_skid2 #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  if (DEPTH != 2) begin : g_depth_check
    $error("hs32_skid2: only DEPTH=2 is supported");
  end

  logic         main_valid_r, main_valid_s;
  logic         skid_valid_r, skid_valid_s;
  logic [W-1:0] main_data_r, main_data_s;
  logic [W-1:0] skid_data_r, skid_data_s;
  logic         ready_r;
  logic         in_fire_s;

  // Next-state selection: MAIN refills from SKID first, then from the input.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    in_fire_s    = valid_i && ready_r;
    if (flush_i) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!main_valid_r || ready_i) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        skid_valid_s = 1'b0;
      end else if (in_fire_s) begin
        main_valid_s = 1'b1;
        main_data_s  = data_i;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_valid_s = 1'b1;
      skid_data_s  = data_i;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Entry registers; ready tracks the emptiness of SKID after this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_data_r  <= '0;
      skid_data_r  <= '0;
      ready_r      <= 1'b1;
    end else begin
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      main_data_r  <= main_data_s;
      skid_data_r  <= skid_data_s;
      ready_r      <= !skid_valid_s;
    end
  end

  assign ready_o = ready_r;
  assign valid_o = main_valid_r;
  assign data_o  = main_data_r;

endmodule

// File: rtl/hs32_agu.sv
// Address generation ahead of hs32_lsu: effective address, store-lane
// replication and alignment checking, delivered through a registered skid buffer.
module hs32_agu
  import hs32_pkg::*;
#(
  parameter int DEPTH             = 2,
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [$bits(hs32_s2pkt)-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [$bits(hs32_s3pkt)-1:0] data_o,
  output logic                    fault_o,
  output logic [31:0]             fault_addr_o
);

  hs32_s2pkt   pkt_s;
  hs32_s3pkt   out_s;
  logic [31:0] sext_s, base_nxt_s, addr_s, aligned_s;
  logic        mis_s, accept_s, drop_s, enq_s, ready_s;
  logic        fault_r;
  logic [31:0] fault_addr_r;

  // Address arithmetic, alignment check and outgoing packet assembly.
  always_comb begin
    pkt_s      = hs32_s2pkt'(data_i);
    sext_s     = {{16{pkt_s.offset[15]}}, pkt_s.offset};
    base_nxt_s = pkt_s.base + sext_s;
    addr_s     = pkt_s.pre ? base_nxt_s : pkt_s.base;
    case (hs32_size_e'(pkt_s.size))
      SZ_BYTE: begin
        mis_s     = 1'b0;
        aligned_s = addr_s;
      end
      SZ_HALF: begin
        mis_s     = addr_s[0];
        aligned_s = {addr_s[31:1], 1'b0};
      end
      default: begin
        mis_s     = |addr_s[1:0];
        aligned_s = {addr_s[31:2], 2'b00};
      end
    endcase
    // With faulting enabled only aligned ops get here, so aligned_s == addr_s.
    out_s.addr     = aligned_s;
    out_s.wdata    = pkt_s.store ? lane_replicate(pkt_s.size, pkt_s.sdata) : 32'd0;
    out_s.write    = pkt_s.store;
    out_s.size     = pkt_s.size;
    out_s.rd       = pkt_s.rd;
    out_s.wb_base  = pkt_s.wb_base;
    out_s.base_nxt = base_nxt_s;
  end

  assign accept_s = valid_i && ready_s && !flush_i;
  assign drop_s   = FAULT_ON_MISALIGN && mis_s;
  assign enq_s    = valid_i && !flush_i && !drop_s;

  // Fault pulse one cycle after a dropped op; the address is held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_r      <= 1'b0;
      fault_addr_r <= 32'd0;
    end else begin
      fault_r <= accept_s && drop_s;
      if (accept_s && drop_s) begin
        fault_addr_r <= addr_s;
      end else begin
        fault_addr_r <= fault_addr_r;
      end
    end
  end

  hs32_skid2 #(
    .W     ($bits(hs32_s3pkt)),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .valid_i (enq_s),
    .ready_o (ready_s),
    .data_i  (out_s),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  assign ready_o      = ready_s;
  assign fault_o      = fault_r;
  assign fault_addr_o = fault_addr_r;

endmodule

// File: tb/tb_hs32_agu.sv
// Self-checking bench for hs32_agu: directed scenarios plus a randomized run
// scored against a queue-based behavioural model.
module tb_hs32_agu;
  import hs32_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o, fault_o;
  logic [31:0] fault_addr_o;
  hs32_s2pkt   data_i;
  hs32_s3pkt   data_o;
  int          n_checks = 0;
  int          n_fail = 0;

  hs32_agu dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .fault_o(fault_o), .fault_addr_o(fault_addr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic hs32_s2pkt mk(input logic store, input logic [1:0] size, input logic pre,
                                   input logic [31:0] base, input logic [15:0] off,
                                   input logic [31:0] sdata);
    hs32_s2pkt p;
    p.store = store; p.size = size; p.rd = 4'd5; p.pre = pre; p.wb_base = 1'b1;
    p.base = base; p.offset = off; p.sdata = sdata;
    return p;
  endfunction

  // Behavioural model: what the LSU should see for a packet, and whether it faults.
  function automatic void model(input hs32_s2pkt p, output hs32_s3pkt o, output bit mis,
                                output logic [31:0] ea);
    int signed   so;
    int unsigned align;
    logic [31:0] nxt, wd;
    so    = $signed(p.offset);
    nxt   = p.base + 32'(so);
    ea    = p.pre ? nxt : p.base;
    align = (p.size == 2'd0) ? 1 : (p.size == 2'd1) ? 2 : 4;
    mis   = (ea % align) != 0;
    if (!p.store) wd = 32'd0;
    else if (p.size == 2'd0) wd = {24'd0, p.sdata[7:0]} * 32'h0101_0101;
    else if (p.size == 2'd1) wd = {16'd0, p.sdata[15:0]} * 32'h0001_0001;
    else wd = p.sdata;
    o.addr = ea; o.wdata = wd; o.write = p.store; o.size = p.size;
    o.rd = p.rd; o.wb_base = p.wb_base; o.base_nxt = nxt;
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_o); end
    n_checks++; if (fault_o !== 1'b0 || fault_addr_o !== 32'd0) begin n_fail++; $display("FAIL rst_fault: got %b/%h want 0/0", fault_o, fault_addr_o); end
    @(negedge clk); reset = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    ready_i = 1'b1; valid_i = 1'b1; data_i = mk(1'b0, 2'd2, 1'b1, 32'h0000_1000, 16'hFFFC, 32'hDEAD_BEEF);
    tick(); valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL wl_valid: got %b want 1", valid_o); end
    n_checks++; if (data_o.addr !== 32'h0000_0FFC || data_o.base_nxt !== 32'h0000_0FFC) begin n_fail++; $display("FAIL wl_addr: got %h/%h want 00000ffc/00000ffc", data_o.addr, data_o.base_nxt); end
    n_checks++; if (data_o.write !== 1'b0 || data_o.wdata !== 32'd0 || data_o.rd !== 4'd5) begin n_fail++; $display("FAIL wl_fields: got w=%b wd=%h rd=%h want 0/0/5", data_o.write, data_o.wdata, data_o.rd); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL wl_drain: got %b want 0", valid_o); end
  endtask

  task automatic test_byte_store();
    ready_i = 1'b1; valid_i = 1'b1; data_i = mk(1'b1, 2'd0, 1'b0, 32'h0000_2003, 16'h0004, 32'h1234_5678);
    tick(); valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || data_o.addr !== 32'h0000_2003 || data_o.base_nxt !== 32'h0000_2007) begin n_fail++; $display("FAIL bs_addr: got v=%b %h/%h want 1 00002003/00002007", valid_o, data_o.addr, data_o.base_nxt); end
    n_checks++; if (data_o.wdata !== 32'h7878_7878 || data_o.write !== 1'b1 || data_o.size !== 2'd0) begin n_fail++; $display("FAIL bs_data: got %h w=%b sz=%0d want 78787878 1 0", data_o.wdata, data_o.write, data_o.size); end
    tick();
  endtask

  task automatic test_back_pressure();
    ready_i = 1'b0; valid_i = 1'b1; data_i = mk(1'b0, 2'd2, 1'b0, 32'h100, 16'h0, 32'h0);
    tick(); data_i = mk(1'b0, 2'd2, 1'b0, 32'h200, 16'h0, 32'h0);
    n_checks++; if (ready_o !== 1'b1 || data_o.addr !== 32'h100) begin n_fail++; $display("FAIL bp_c1: got rdy=%b addr=%h want 1 100", ready_o, data_o.addr); end
    tick(); data_i = mk(1'b0, 2'd2, 1'b0, 32'h300, 16'h0, 32'h0);
    n_checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o.addr !== 32'h100) begin n_fail++; $display("FAIL bp_c2: got rdy=%b v=%b addr=%h want 0 1 100", ready_o, valid_o, data_o.addr); end
    tick();
    n_checks++; if (ready_o !== 1'b0 || data_o.addr !== 32'h100) begin n_fail++; $display("FAIL bp_hold: got rdy=%b addr=%h want 0 100", ready_o, data_o.addr); end
    ready_i = 1'b1;
    tick();
    n_checks++; if (valid_o !== 1'b1 || data_o.addr !== 32'h200 || ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_b: got v=%b addr=%h rdy=%b want 1 200 1", valid_o, data_o.addr, ready_o); end
    tick(); valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || data_o.addr !== 32'h300) begin n_fail++; $display("FAIL bp_c: got v=%b addr=%h want 1 300", valid_o, data_o.addr); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", valid_o); end
  endtask

  task automatic test_misalign();
    ready_i = 1'b1; valid_i = 1'b1; data_i = mk(1'b0, 2'd1, 1'b0, 32'h3001, 16'h0, 32'h0);
    tick(); data_i = mk(1'b0, 2'd1, 1'b0, 32'h3002, 16'h0, 32'h0);
    n_checks++; if (fault_o !== 1'b1 || valid_o !== 1'b0 || fault_addr_o !== 32'h3001) begin n_fail++; $display("FAIL ma_fault: got f=%b v=%b fa=%h want 1 0 3001", fault_o, valid_o, fault_addr_o); end
    tick(); valid_i = 1'b0;
    n_checks++; if (fault_o !== 1'b0 || valid_o !== 1'b1 || data_o.addr !== 32'h3002 || fault_addr_o !== 32'h3001) begin n_fail++; $display("FAIL ma_next: got f=%b v=%b addr=%h fa=%h want 0 1 3002 3001", fault_o, valid_o, data_o.addr, fault_addr_o); end
    tick();
  endtask

  task automatic test_flush();
    ready_i = 1'b0; valid_i = 1'b1; data_i = mk(1'b0, 2'd2, 1'b0, 32'h500, 16'h0, 32'h0);
    tick(); data_i = mk(1'b0, 2'd2, 1'b0, 32'h504, 16'h0, 32'h0);
    tick(); valid_i = 1'b0;
    n_checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin n_fail++; $display("FAIL fl_full: got rdy=%b v=%b want 0 1", ready_o, valid_o); end
    flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", valid_o); end
    tick();
    n_checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_ready: got rdy=%b v=%b want 1 0", ready_o, valid_o); end
    flush_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = mk(1'b0, 2'd2, 1'b0, 32'h4003, 16'h0, 32'h0);
    tick(); flush_i = 1'b0; valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0 || fault_o !== 1'b0 || fault_addr_o !== 32'h3001) begin n_fail++; $display("FAIL fl_discard: got v=%b f=%b fa=%h want 0 0 3001", valid_o, fault_o, fault_addr_o); end
    tick();
  endtask

  task automatic test_wrap();
    ready_i = 1'b1; valid_i = 1'b1; data_i = mk(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFC, 16'h0008, 32'h0);
    tick(); valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || data_o.addr !== 32'h4 || data_o.base_nxt !== 32'h4) begin n_fail++; $display("FAIL wrap: got v=%b %h/%h want 1 4/4", valid_o, data_o.addr, data_o.base_nxt); end
    tick();
  endtask

  task automatic test_random();
    hs32_s3pkt   q[$];
    hs32_s3pkt   o;
    hs32_s2pkt   p;
    bit          mis, exp_fault, have_fa;
    logic [31:0] ea, exp_fa;
    bit          rdy_m, vld_m;
    exp_fault = 1'b0; have_fa = 1'b0; exp_fa = 32'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++; if (valid_o !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, valid_o, q.size() > 0); end
      n_checks++; if (ready_o !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", cyc, ready_o, q.size() < 2); end
      n_checks++; if (fault_o !== exp_fault) begin n_fail++; $display("FAIL rnd_fault @%0d: got %b want %b", cyc, fault_o, exp_fault); end
      if (q.size() > 0) begin
        n_checks++; if (data_o !== q[0]) begin n_fail++; $display("FAIL rnd_data @%0d: got %h want %h", cyc, data_o, q[0]); end
      end
      if (have_fa) begin
        n_checks++; if (fault_addr_o !== exp_fa) begin n_fail++; $display("FAIL rnd_faddr @%0d: got %h want %h", cyc, fault_addr_o, exp_fa); end
      end
      p.store = 1'($urandom()); p.size = 2'($urandom_range(0, 3)); p.rd = 4'($urandom());
      p.pre = 1'($urandom()); p.wb_base = 1'($urandom()); p.sdata = $urandom();
      p.base = $urandom(); p.offset = 16'($urandom());
      if ($urandom_range(0, 3) != 0) p.base[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) p.offset[1:0] = 2'b00;
      data_i  = p;
      valid_i = ($urandom_range(0, 9) < 6);
      ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 31) == 0);
      rdy_m = q.size() < 2;
      vld_m = q.size() > 0;
      exp_fault = 1'b0;
      if (flush_i) begin
        q.delete();
      end else begin
        if (vld_m && ready_i) void'(q.pop_front());
        if (valid_i && rdy_m) begin
          model(p, o, mis, ea);
          if (mis) begin exp_fault = 1'b1; exp_fa = ea; have_fa = 1'b1; end
          else q.push_back(o);
        end
      end
      tick();
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0; valid_i = 1'b1; data_i = mk(1'b1, 2'd2, 1'b0, 32'h700, 16'h0, 32'hCAFE_F00D);
    tick(); data_i = mk(1'b1, 2'd2, 1'b0, 32'h704, 16'h0, 32'h1111_2222);
    tick(); valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL ar_pre: got v=%b rdy=%b want 1 0", valid_o, ready_o); end
    #3 reset = 1'b1;
    #1;
    n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== '0) begin n_fail++; $display("FAIL ar_out: got v=%b rdy=%b d=%h want 0 1 0", valid_o, ready_o, data_o); end
    n_checks++; if (fault_o !== 1'b0 || fault_addr_o !== 32'd0) begin n_fail++; $display("FAIL ar_fault: got %b/%h want 0/0", fault_o, fault_addr_o); end
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_back_pressure();
    test_misalign();
    test_flush();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
